// File: rtl/stream_slice_serializer.sv
// stream_slice_serializer: captures one IN_W-bit word, optionally reverses its
// SLICE_W-bit slice order at capture time, then emits it as OUT_W-bit beats,
// most significant first, over a valid/ready link with packet framing.
// Optional feature macro: STREAM_SER_XCHK_EN appends an XOR check beat
// after the final word of each packet.
module stream_slice_serializer #(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SLICE_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_dir,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned NB  = IN_W / OUT_W;
  localparam int unsigned NS  = IN_W / SLICE_W;
  localparam int unsigned BCW = $clog2(NB + 1);

  // Reject geometries where words do not split evenly into beats and slices
  if ((IN_W % OUT_W) != 0) begin : g_bad_out_w
    $error("stream_slice_serializer: IN_W must be a multiple of OUT_W");
  end
  if ((IN_W % SLICE_W) != 0) begin : g_bad_slice_w
    $error("stream_slice_serializer: IN_W must be a multiple of SLICE_W");
  end

`ifdef STREAM_SER_XCHK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, CHK} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t            state_q;
  logic [IN_W-1:0]   data_q;
  logic [IN_W-1:0]   data_d;
  logic [BCW-1:0]    beat_q;
  logic              last_q;
  logic              final_beat;
  logic              chk_pending;
  logic              capture;
`ifdef STREAM_SER_XCHK_EN
  logic [OUT_W-1:0]  xor_q;
`endif

  // Slice reorder applied at capture; bits inside a slice keep their order
  always_comb begin
    data_d = in_data;
    if (in_dir) begin
      for (int unsigned k = 0; k < NS; k++) begin
        data_d[k*SLICE_W +: SLICE_W] = in_data[(NS-1-k)*SLICE_W +: SLICE_W];
      end
    end
  end

  assign final_beat = (state_q == SHIFT) && (beat_q == BCW'(NB - 1));

`ifdef STREAM_SER_XCHK_EN
  assign chk_pending = last_q;
`else
  assign chk_pending = 1'b0;
`endif

  // Accept in IDLE, or while the final beat leaves unless a check beat follows
  assign in_ready = (state_q == IDLE) || (final_beat && out_ready && !chk_pending);
  assign capture  = in_valid && in_ready;

  assign out_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);

`ifdef STREAM_SER_XCHK_EN
  assign out_data = (state_q == CHK) ? xor_q : data_q[IN_W-1 -: OUT_W];
  assign out_last = (state_q == CHK);
`else
  assign out_data = data_q[IN_W-1 -: OUT_W];
  assign out_last = final_beat && last_q;
`endif

  // Serializer FSM: holding register, beat counter, packet framing
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      beat_q  <= '0;
      last_q  <= 1'b0;
`ifdef STREAM_SER_XCHK_EN
      xor_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            data_q  <= data_d;
            beat_q  <= '0;
            last_q  <= in_last;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
`ifdef STREAM_SER_XCHK_EN
            xor_q <= xor_q ^ out_data;
`endif
            if (final_beat) begin
              beat_q <= '0;
              if (capture) begin
                data_q  <= data_d;
                last_q  <= in_last;
                state_q <= SHIFT;
`ifdef STREAM_SER_XCHK_EN
              end else if (last_q) begin
                data_q  <= '0;
                state_q <= CHK;
`endif
              end else begin
                data_q  <= '0;
                last_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              data_q <= data_q << OUT_W;
              beat_q <= beat_q + BCW'(1);
            end
          end
        end
`ifdef STREAM_SER_XCHK_EN
        CHK: begin
          if (out_ready) begin
            xor_q   <= '0;
            last_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/stream_slice_serializer.md
Name: stream_slice_serializer

Overview:
Hardware form of the SV streaming operator. The block captures one wide word, reorders it either left-to-right ({>> SLICE_W {x}}) or right-to-left ({<< SLICE_W {x}}), and emits the result as OUT_W-bit beats, most significant first, over a valid/ready link. It sits between the packet builder (header/len/payload/crc words) and the byte-wide link transmitter. It extends the fixed byte-stream pack idiom with a parametrised slice size and output width, a per-word direction select, and packet framing.

Parameters:
IN_W, 32, input word width; must be a multiple of OUT_W and of SLICE_W (elaboration-time $error otherwise)
OUT_W, 8, output beat width
SLICE_W, 8, streaming slice size used when direction is right-to-left

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  IN_W  word to stream
in_dir  input  1  0 = {>>} keep order, 1 = {<<} reverse slice order; sampled with in_data
in_last  input  1  word is the last of a packet; sampled with in_data
out_valid  output  1  beat valid
out_ready  input  1  sink accepts beat
out_data  output  OUT_W  current beat
out_last  output  1  final beat of packet
busy  output  1  holding register occupied

Behaviour:
- Derived values: NB = IN_W/OUT_W beats per word, NS = IN_W/SLICE_W slices per word. The beat counter is $clog2(NB+1) bits wide.
- States: IDLE (register empty) and SHIFT (emitting beats). With STREAM_SER_XCHK_EN there is an additional state CHK.
- Capture happens when in_valid && in_ready. The word is reordered at capture, not at output:
  - in_dir=0: the register loads in_data unchanged.
  - in_dir=1: register slice k (bits [k*SLICE_W +: SLICE_W]) loads in_data slice NS-1-k.
  - Bit order inside a slice is never changed.
- Output and latency:
  - out_data is the top OUT_W bits of the register. Each accepted beat (out_valid && out_ready) shifts the register left by OUT_W.
  - The first beat is presented on the cycle after capture (1-cycle latency).
  - out_data and out_last hold stable while out_valid && !out_ready.
- in_ready:
  - High in IDLE.
  - High in SHIFT only on the cycle the final beat (beat NB-1) is accepted. This allows back-to-back words with no bubble.
  - Low otherwise.
- out_last = 1 only on beat NB-1 of a word that was captured with in_last=1.
- Transitions:
  - IDLE -> SHIFT on capture.
  - On acceptance of the final beat: SHIFT -> SHIFT if a new word is captured in the same cycle, otherwise -> IDLE.
- busy = (state != IDLE).
- Simultaneous events: a capture and the final-beat acceptance in the same cycle load the new word and reset the beat counter to 0. The old final beat has already been transferred.
- Reset, including mid-word: state=IDLE, beat counter=0, register=0. Outputs: out_valid=0, out_last=0, out_data=0, busy=0. in_ready=1 from the first cycle after reset deasserts. A partially sent word is dropped and no out_last is produced for it.
- in_valid without in_ready has no effect. The source must hold in_data, in_dir and in_last stable until accepted.

Optional Feature:
STREAM_SER_XCHK_EN:
- Defined:
  - After the final beat of an in_last word, the block enters CHK and emits one extra beat: the XOR of all OUT_W beats of the packet.
  - out_last moves from the final data beat to the check beat.
  - in_ready is low in CHK.
  - The XOR accumulator clears on reset and after the check beat is accepted.
- Undefined: no CHK state, no accumulator, no extra beat.

Test Plan:
- IN_W=32, OUT_W=8, SLICE_W=8; word 32'h41424344 ("ABCD"), in_dir=0, in_last=1, out_ready=1 -> beats 41,42,43,44 on cycles 1-4 after capture, out_last only on 44.
- Same word, in_dir=1 -> beats 44,43,42,41 ("DCBA"). Rebuild with SLICE_W=16 -> beats 43,44,41,42.
- Back-to-back: words 32'h01020304 then 32'h0A0B0C0D, in_valid held high, out_ready=1 -> 8 consecutive beats with no gap, in_ready high exactly on the 4th-beat cycle.
- Backpressure: drop out_ready for 3 cycles at beat 2 -> out_data stays 42 and out_valid stays 1. No beat is lost or duplicated and in_ready remains 0.
- Assert reset after beat 2 -> next cycle out_valid=0, busy=0, in_ready=1. The next word 32'h11223344 streams cleanly as 11,22,33,44.
- With STREAM_SER_XCHK_EN: word 32'h41424344, in_last=1 -> beats 41,42,43,44, then check beat 8'h04 with out_last=1 on it only.
